ncl_sync_bridge: RTL and testbench
==================================

Name: ncl_sync_bridge

Overview:
- Clocked master for one dual-rail NCL block. Converts a synchronous valid/ready input stream into DATA/NULL wavefronts on the block's dual-rail inputs, paced by the block's `ackout`.
- Detects completion on the block's dual-rail outputs, drives `ackin` back to the block, and presents each result as a synchronous valid/ready word.
- Lets synchronous logic exercise NCL blocks such as `ncl_up_counter` without a hand-written environment.

Parameters:
- `IN_W`, 2: number of dual-rail input bits driven into the NCL block.
- `OUT_W`, 8: number of dual-rail output bits captured from the NCL block.
- `SYNC_STAGES`, 2: flop stages on every asynchronous input (`ackout`, `f_out`, `t_out`); legal range 2..4.
- `TIMEOUT`, 1024: watchdog limit in `i_clk` cycles; used only with `NCL_TIMEOUT_EN`.

Ports:
- `i_clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `s_valid`  input  1  input word available.
- `s_ready`  output  1  bridge can accept an input word.
- `s_data`  input  IN_W  input word.
- `f_in`  output  IN_W  false rails to the NCL block.
- `t_in`  output  IN_W  true rails to the NCL block.
- `ackout`  input  1  NCL block ready. 1 = request DATA; 0 = DATA consumed, request NULL.
- `f_out`  input  OUT_W  false rails from the NCL block.
- `t_out`  input  OUT_W  true rails from the NCL block.
- `ackin`  output  1  acknowledge to the NCL block. 1 = request DATA; 0 = request NULL.
- `m_valid`  output  1  captured result valid.
- `m_ready`  input  1  downstream accepts the result.
- `m_data`  output  OUT_W  captured result (true rails).
- `err`  output  2  bit0 = illegal rail pair (sticky); bit1 = timeout (sticky).

Behaviour:
- **Reset values.** Reset is asynchronous, active-low. On reset:
  - `f_in` = `t_in` = 0 (NULL), `ackin` = 1, `s_ready` = 0.
  - `m_valid` = 0, `m_data` = 0, `err` = 0.
  - All synchronizer flops = 0; TX FSM = `TX_IDLE`; RX FSM = `RX_WAIT_DATA`.
- **Reset mid-operation.** Reset asserted during a DATA phase forces NULL immediately.
  - After release, the TX FSM waits for the synchronized `ackout` to read 1 before accepting input.
- **Synchronization.** `ackout_s`, `t_s` and `f_s` are the `SYNC_STAGES`-deep synchronized copies of the async inputs.
- **TX FSM (all outputs registered).**
  - `TX_IDLE`: rails NULL; `s_ready` = `ackout_s`. On `s_valid & s_ready`, latch `s_data` and go to `TX_DATA`.
    - The rails show DATA in the cycle after acceptance: latency 1.
  - `TX_DATA`: `t_in` = latched data, `f_in` = ~latched data; `s_ready` = 0. When `ackout_s` = 0, go to `TX_NULL`.
  - `TX_NULL`: rails = 0; `s_ready` = 0. When `ackout_s` = 1, go to `TX_IDLE`.
  - One input word is accepted per full DATA/NULL cycle; no new token is accepted before NULL is acknowledged.
- **Completion detection** on synchronized rails:
  - `all_data` = &(`t_s` | `f_s`) with no bit where `t_s` & `f_s`.
  - `all_null` = ~|(`t_s` | `f_s`).
  - Either condition is accepted only when it holds on 2 consecutive samples (skew filter).
- **RX FSM.**
  - `RX_WAIT_DATA` (`ackin` = 1): on filtered `all_data` and an output slot free (`!m_valid | m_ready`):
    - `m_data` <= `t_s`, `m_valid` <= 1, `ackin` <= 0; go to `RX_WAIT_NULL`.
    - If the slot is not free, stay; `ackin` remains 1, which stalls the NCL pipeline (backpressure).
  - `RX_WAIT_NULL` (`ackin` = 0): on filtered `all_null`, `ackin` <= 1; go to `RX_WAIT_DATA`.
- **Output handshake.** `m_valid` clears on `m_valid & m_ready` unless a new capture happens in the same cycle; a capture in that cycle wins.
- **Illegal rail pair.** `t_s[i]` & `f_s[i]` both high on any bit sets `err[0]`, which is sticky until reset. The RX FSM does not advance on that sample.
- **Concurrency.** TX and RX run independently. A simultaneous TX acceptance and RX capture in one cycle are both performed.
- **Width.** `m_data` carries the true rails only, with no arithmetic; bit i of the output maps to rail pair i.

Optional Feature:
- Macro: `NCL_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit watchdog counts cycles spent in `TX_DATA`, `TX_NULL` or `RX_WAIT_NULL`, and resets on every state change.
  - When the count reaches `TIMEOUT`, `err[1]` is set (sticky). The FSMs keep waiting; there is no forced recovery.
- **Undefined:** no counter logic; `err[1]` is tied to 0.

Test Plan:
1. **Reset.** Hold `reset` = 0 for 10 cycles with `ackout` = 1 → rails 0, `ackin` = 1, `m_valid` = 0, `err` = 0. After release, `s_ready` rises 2 cycles later (`SYNC_STAGES` = 2).
2. **Counter loopback, count-up.** With `ncl_up_counter` attached and `s_data` = {clr=0, enable=1}, send 9 words with `m_ready` = 1 → `m_data` sequence 1..9. Each `ackin` low pulse is followed by NULL, and `err` = 0.
3. **Clear and wrap.** Send 256 enable words → `m_data` wraps 255 → 0. Then send clr=1 → next `m_data` = 0. Then send clr=0, enable=0 → `m_data` holds 0.
4. **Backpressure.** Hold `m_ready` = 0 after one capture, then present a second DATA wavefront → `ackin` stays 1 and `m_valid` = 1 with the first value. Raising `m_ready` → second value captured in the next qualifying cycle.
5. **Illegal rails.** Force `t_out[3]` = `f_out[3]` = 1 while other bits are valid → `err[0]` = 1 and no capture. Release to a valid code → capture proceeds; `err[0]` stays 1 until reset.
6. **Timeout (`NCL_TIMEOUT_EN`, `TIMEOUT` = 32).** Keep `ackout` = 1 after a DATA launch → `err[1]` set at cycle 32 in `TX_DATA`, and the rails still hold DATA.

Source files
------------

// File: rtl/ncl_sync_bridge_if.sv
// -----------------------------------------------------------------------------
// ncl_sync_bridge_if
// Bundles every signal between ncl_sync_bridge and its surroundings:
//   - synchronous input stream   : s_valid, s_ready, s_data[IN_W]
//   - dual-rail side to NCL block: f_in/t_in[IN_W], ackout, f_out/t_out[OUT_W], ackin
//   - synchronous result stream  : m_valid, m_ready, m_data[OUT_W]
//   - status                     : err[1:0]
// Modports:
//   slave  - the bridge itself
//   master - the environment around the bridge (stream source/sink and NCL block)
// -----------------------------------------------------------------------------
interface ncl_sync_bridge_if #(
   parameter int IN_W  = 2,
   parameter int OUT_W = 8
);
   logic             s_valid;
   logic             s_ready;
   logic [IN_W-1:0]  s_data;
   logic [IN_W-1:0]  f_in;
   logic [IN_W-1:0]  t_in;
   logic             ackout;
   logic [OUT_W-1:0] f_out;
   logic [OUT_W-1:0] t_out;
   logic             ackin;
   logic             m_valid;
   logic             m_ready;
   logic [OUT_W-1:0] m_data;
   logic [1:0]       err;

   modport slave (
      input  s_valid, s_data, ackout, f_out, t_out, m_ready,
      output s_ready, f_in, t_in, ackin, m_valid, m_data, err
   );

   modport master (
      output s_valid, s_data, ackout, f_out, t_out, m_ready,
      input  s_ready, f_in, t_in, ackin, m_valid, m_data, err
   );
endinterface

// File: rtl/ncl_sync_bridge.sv
// -----------------------------------------------------------------------------
// ncl_sync_bridge
// Clocked master for one dual-rail NCL block. A synchronous valid/ready word is
// launched as a DATA wavefront on t_in/f_in, returned to NULL once the block
// drops ackout, and the next word is only taken after ackout rises again.
// The block's dual-rail outputs are synchronized, completion is detected
// (all DATA / all NULL, each confirmed on two consecutive samples), ackin is
// driven back and the true rails are presented as a valid/ready result word.
//
// Ports:
//   i_clk  - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - ncl_sync_bridge_if.slave (s_* input stream, NCL rails and
//            acknowledges, m_* result stream, err[1:0])
//
// err[0]: illegal rail pair seen (sticky until reset)
// err[1]: watchdog timeout (sticky), only with `NCL_TIMEOUT_EN defined;
//         tied to 0 otherwise.
// Optional feature macro: NCL_TIMEOUT_EN
// -----------------------------------------------------------------------------
module ncl_sync_bridge #(
   parameter int IN_W        = 2,
   parameter int OUT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input logic                i_clk,
   input logic                reset,
   ncl_sync_bridge_if.slave   bus
);

   localparam bit PARAMS_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                              (TIMEOUT >= 1) && (TIMEOUT <= 65535);

   generate
      if (!PARAMS_OK) begin : g_param_check
         $error("ncl_sync_bridge: SYNC_STAGES must be 2..4 and TIMEOUT 1..65535");
      end
   endgenerate

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_DATA = 2'd1,
      TX_NULL = 2'd2
   } tx_state_t;

   typedef enum logic {
      RX_WAIT_DATA = 1'b0,
      RX_WAIT_NULL = 1'b1
   } rx_state_t;

   // ---------------------------------------------------------------------------
   // Stage: synchronizers for the asynchronous NCL-side inputs
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] ackout_sync;
   logic [OUT_W-1:0]       t_sync [SYNC_STAGES];
   logic [OUT_W-1:0]       f_sync [SYNC_STAGES];
   logic                   ackout_s;
   logic                   ackout_s_next;
   logic [OUT_W-1:0]       t_s;
   logic [OUT_W-1:0]       f_s;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         ackout_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            t_sync[i] <= '0;
            f_sync[i] <= '0;
         end
      end else begin
         ackout_sync <= {ackout_sync[SYNC_STAGES-2:0], bus.ackout};
         t_sync[0]   <= bus.t_out;
         f_sync[0]   <= bus.f_out;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            t_sync[i] <= t_sync[i-1];
            f_sync[i] <= f_sync[i-1];
         end
      end
   end

   assign ackout_s      = ackout_sync[SYNC_STAGES-1];
   // Value ackout_s will take after the next edge; lets s_ready be a flop
   // while still tracking ackout_s with no extra cycle of delay.
   assign ackout_s_next = ackout_sync[SYNC_STAGES-2];
   assign t_s           = t_sync[SYNC_STAGES-1];
   assign f_s           = f_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Stage: TX FSM - input stream to DATA/NULL wavefronts
   // ---------------------------------------------------------------------------
   tx_state_t       tx_state;
   tx_state_t       tx_next;
   logic [IN_W-1:0] t_in_q;
   logic [IN_W-1:0] f_in_q;
   logic [IN_W-1:0] t_in_d;
   logic [IN_W-1:0] f_in_d;
   logic            s_ready_q;
   logic            s_ready_d;
   logic            tx_accept;

   assign tx_accept = bus.s_valid & s_ready_q;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         tx_state  <= TX_IDLE;
         t_in_q    <= '0;
         f_in_q    <= '0;
         s_ready_q <= 1'b0;
      end else begin
         tx_state  <= tx_next;
         t_in_q    <= t_in_d;
         f_in_q    <= f_in_d;
         s_ready_q <= s_ready_d;
      end
   end

   always_comb begin
      tx_next = tx_state;
      t_in_d  = t_in_q;
      f_in_d  = f_in_q;
      case (tx_state)
         TX_IDLE: begin
            if (tx_accept) begin
               tx_next = TX_DATA;
               t_in_d  = bus.s_data;
               f_in_d  = ~bus.s_data;
            end
         end
         TX_DATA: begin
            if (!ackout_s) begin
               tx_next = TX_NULL;
            end
         end
         TX_NULL: begin
            if (ackout_s) begin
               tx_next = TX_IDLE;
            end
         end
         default: begin
            tx_next = TX_IDLE;
         end
      endcase
      // Rails carry the latched word only while in TX_DATA; NULL otherwise.
      if (tx_next != TX_DATA) begin
         t_in_d = '0;
         f_in_d = '0;
      end
      s_ready_d = (tx_next == TX_IDLE) & ackout_s_next;
   end

   // ---------------------------------------------------------------------------
   // Stage: completion detection with two-sample skew filter
   // ---------------------------------------------------------------------------
   logic             illegal_now;
   logic             all_data_now;
   logic             all_null_now;
   logic             all_data_prev;
   logic             all_null_prev;
   logic             data_seen;
   logic             null_seen;
   logic             err_illegal;
   logic             err_timeout;

   assign illegal_now  = |(t_s & f_s);
   assign all_data_now = (&(t_s | f_s)) & ~illegal_now;
   assign all_null_now = ~|(t_s | f_s);
   assign data_seen    = all_data_now & all_data_prev;
   assign null_seen    = all_null_now & all_null_prev;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         all_data_prev <= 1'b0;
         all_null_prev <= 1'b0;
         err_illegal   <= 1'b0;
      end else begin
         all_data_prev <= all_data_now;
         all_null_prev <= all_null_now;
         if (illegal_now) begin
            err_illegal <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage: RX FSM - capture, ackin and result handshake
   // ---------------------------------------------------------------------------
   rx_state_t        rx_state;
   rx_state_t        rx_next;
   logic             ackin_q;
   logic             ackin_d;
   logic             capture;
   logic             slot_free;
   logic             m_valid_q;
   logic [OUT_W-1:0] m_data_q;

   assign slot_free = ~m_valid_q | bus.m_ready;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         rx_state <= RX_WAIT_DATA;
         ackin_q  <= 1'b1;
      end else begin
         rx_state <= rx_next;
         ackin_q  <= ackin_d;
      end
   end

   always_comb begin
      rx_next = rx_state;
      capture = 1'b0;
      case (rx_state)
         RX_WAIT_DATA: begin
            // Holding ackin high while the slot is busy stalls the NCL block.
            if (data_seen && slot_free) begin
               capture = 1'b1;
               rx_next = RX_WAIT_NULL;
            end
         end
         RX_WAIT_NULL: begin
            if (null_seen) begin
               rx_next = RX_WAIT_DATA;
            end
         end
         default: begin
            rx_next = RX_WAIT_DATA;
         end
      endcase
      ackin_d = (rx_next == RX_WAIT_DATA);
   end

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         // A new capture takes priority over the consumer draining the slot.
         if (capture) begin
            m_valid_q <= 1'b1;
            m_data_q  <= t_s;
         end else if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage: optional watchdog
   // ---------------------------------------------------------------------------
`ifdef NCL_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT - 1);

   logic [15:0] wd_cnt;
   logic        wd_active;
   logic        state_change;

   assign wd_active    = (tx_state == TX_DATA) || (tx_state == TX_NULL) ||
                         (rx_state == RX_WAIT_NULL);
   assign state_change = (tx_next != tx_state) || (rx_next != rx_state);

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state_change || !wd_active) begin
            wd_cnt <= '0;
         end else if (wd_cnt != 16'hFFFF) begin
            wd_cnt <= wd_cnt + 16'd1;
         end
         // Flag only; both FSMs keep waiting for the block.
         if (wd_active && !state_change && (wd_cnt == TIMEOUT_LIM)) begin
            err_timeout <= 1'b1;
         end
      end
   end
`else
   assign err_timeout = 1'b0;
`endif

   assign bus.s_ready = s_ready_q;
   assign bus.t_in    = t_in_q;
   assign bus.f_in    = f_in_q;
   assign bus.ackin   = ackin_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.err     = {err_timeout, err_illegal};

endmodule

// File: tb/tb_ncl_sync_bridge.sv
// -----------------------------------------------------------------------------
// tb_ncl_sync_bridge
// Drives ncl_sync_bridge against a behavioural 8-bit NCL up-counter
// (s_data = {clr, enable}) with randomized phase delays and per-bit skew,
// or against directly driven rails for the illegal-code and reset scenarios.
// Expected results come from a counter model updated per accepted word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ncl_sync_bridge;
   localparam int IN_W        = 2;
   localparam int OUT_W       = 8;
   localparam int SYNC_STAGES = 2;
`ifdef NCL_TIMEOUT_EN
   localparam int TB_TIMEOUT  = 32;
`else
   localparam int TB_TIMEOUT  = 1024;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ncl_sync_bridge_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   ncl_sync_bridge #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .i_clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Environment drive: stream source/sink and NCL block (model or manual)
   logic             s_valid = 1'b0;
   logic [IN_W-1:0]  s_data  = '0;
   logic             m_ready = 1'b0;
   bit               blk_en  = 1'b0;
   logic             blk_ack = 1'b1;
   logic [OUT_W-1:0] blk_t   = '0;
   logic [OUT_W-1:0] blk_f   = '0;
   logic [OUT_W-1:0] blk_cnt = '0;
   logic [IN_W-1:0]  blk_word;
   logic             man_ack = 1'b1;
   logic [OUT_W-1:0] man_t   = '0;
   logic [OUT_W-1:0] man_f   = '0;

   assign bus.s_valid = s_valid;
   assign bus.s_data  = s_data;
   assign bus.m_ready = m_ready;
   assign bus.ackout  = blk_en ? blk_ack : man_ack;
   assign bus.t_out   = blk_en ? blk_t   : man_t;
   assign bus.f_out   = blk_en ? blk_f   : man_f;

   // Behavioural NCL up-counter: DATA out when inputs are DATA and ackin asks
   // for DATA; NULL out when inputs are NULL and ackin asks for NULL.
   always begin
      wait (blk_en);
      wait (!blk_en || ((&(bus.t_in | bus.f_in)) && bus.ackin === 1'b1));
      if (blk_en) begin
         #($urandom_range(1, 7));
         blk_word = bus.t_in;
         if (blk_word[1]) blk_cnt = '0;
         else if (blk_word[0]) blk_cnt = blk_cnt + 8'd1;
         for (int i = 0; i < OUT_W; i++) begin
            #($urandom_range(0, 3));
            if (blk_cnt[i]) blk_t[i] = 1'b1;
            else blk_f[i] = 1'b1;
         end
         blk_ack = 1'b0;
         wait (!blk_en || ((bus.t_in | bus.f_in) == '0 && bus.ackin === 1'b0));
         if (blk_en) begin
            #($urandom_range(1, 7));
            for (int i = 0; i < OUT_W; i++) begin
               #($urandom_range(0, 3));
               blk_t[i] = 1'b0;
               blk_f[i] = 1'b0;
            end
            blk_ack = 1'b1;
         end
      end
   end

   // Downstream ready: 0 = hold off, 1 = always ready, 2 = random
   int rdy_mode = 1;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Result monitor and ackin protocol observation
   logic [OUT_W-1:0] got_q[$];
   int               ackin_falls   = 0;
   int               null_viol     = 0;
   logic             ackin_prev    = 1'b1;
   logic             out_null_prev = 1'b1;
   always @(negedge clk) begin
      if (reset) begin
         if (bus.m_valid && m_ready) got_q.push_back(bus.m_data);
         if (ackin_prev && !bus.ackin) ackin_falls++;
         if (!ackin_prev && bus.ackin && !out_null_prev) null_viol++;
      end
      ackin_prev    = bus.ackin;
      out_null_prev = ((bus.t_out | bus.f_out) == '0);
   end

   // Reference counter model
   logic [OUT_W-1:0] model_cnt = '0;

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
      $fatal(1, "global timeout");
   end

   task automatic send_word(input logic [IN_W-1:0] d);
      int n = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      while (!bus.s_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_accept: s_ready=%b required 1 within 300 cycles", bus.s_ready);
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      checks++;
      if (bus.t_in !== d || bus.f_in !== ~d) begin
         errors++;
         $display("FAIL rails_latency: t_in=%b f_in=%b required t_in=%b f_in=%b",
                  bus.t_in, bus.f_in, d, ~d);
      end
   endtask

   task automatic xfer(input logic [IN_W-1:0] w, input string tag, output logic [OUT_W-1:0] got);
      int n = 0;
      logic [OUT_W-1:0] exp;
      send_word(w);
      if (w[1]) model_cnt = '0;
      else if (w[0]) model_cnt = model_cnt + 8'd1;
      exp = model_cnt;
      while (got_q.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (got_q.size() == 0) begin
         errors++;
         got = 'x;
         $display("FAIL %s_result: no result within 400 cycles, required %0d", tag, exp);
      end else begin
         got = got_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL %s_result: m_data=%0d required %0d", tag, got, exp);
         end
      end
   endtask

   task automatic wait_quiet();
      int n = 0;
      while (!(bus.ackin === 1'b1 && bus.ackout === 1'b1 && bus.s_ready === 1'b1 &&
               (bus.t_out | bus.f_out) == '0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL quiesce: ackin=%b ackout=%b s_ready=%b required all 1", bus.ackin,
                  bus.ackout, bus.s_ready);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      man_ack = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (bus.t_in !== '0 || bus.f_in !== '0) begin
         errors++;
         $display("FAIL reset_rails: t_in=%b f_in=%b required 00/00", bus.t_in, bus.f_in);
      end
      checks++;
      if (bus.ackin !== 1'b1 || bus.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ack: ackin=%b s_ready=%b required 1/0", bus.ackin, bus.s_ready);
      end
      checks++;
      if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.err !== 2'b00) begin
         errors++;
         $display("FAIL reset_out: m_valid=%b m_data=%h err=%b required 0/00/00",
                  bus.m_valid, bus.m_data, bus.err);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_sready_c1: s_ready=%b required 0", bus.s_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_sready_c2: s_ready=%b required 1", bus.s_ready);
      end
   endtask

   task automatic test_count_up();
      int falls0;
      logic [OUT_W-1:0] g;
      int n = 0;
      rdy_mode = 1;
      repeat (2) @(negedge clk);
      falls0 = ackin_falls;
      for (int i = 0; i < 9; i++) begin
         xfer(2'b01, "count", g);
         checks++;
         if (g !== 8'(i + 1)) begin
            errors++;
            $display("FAIL count_seq: m_data=%0d required %0d", g, i + 1);
         end
      end
      while (bus.ackin !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ackin_falls - falls0 != 9 || null_viol != 0) begin
         errors++;
         $display("FAIL count_ackin: ackin pulses=%0d null violations=%0d required 9/0",
                  ackin_falls - falls0, null_viol);
      end
      checks++;
      if (bus.err !== 2'b00) begin
         errors++;
         $display("FAIL count_err: err=%b required 00", bus.err);
      end
   endtask

   task automatic test_clear_wrap();
      logic [OUT_W-1:0] g;
      logic [OUT_W-1:0] prev;
      bit saw_wrap = 1'b0;
      prev = model_cnt;
      for (int i = 0; i < 256; i++) begin
         xfer(2'b01, "wrap", g);
         if (prev == 8'd255 && g == 8'd0) saw_wrap = 1'b1;
         prev = g;
      end
      checks++;
      if (!saw_wrap) begin
         errors++;
         $display("FAIL wrap_seen: 255->0 transition seen=%0d required 1", saw_wrap);
      end
      xfer(2'b10, "clear", g);
      checks++;
      if (g !== 8'd0) begin
         errors++;
         $display("FAIL clear_value: m_data=%0d required 0", g);
      end
      for (int i = 0; i < 2; i++) begin
         xfer(2'b00, "hold", g);
         checks++;
         if (g !== 8'd0) begin
            errors++;
            $display("FAIL hold_value: m_data=%0d required 0", g);
         end
      end
   endtask

   task automatic test_random();
      logic [OUT_W-1:0] g;
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         xfer(IN_W'($urandom_range(0, 3)), "random", g);
      end
      rdy_mode = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (null_viol != 0 || bus.err !== 2'b00) begin
         errors++;
         $display("FAIL random_proto: null violations=%0d err=%b required 0/00", null_viol, bus.err);
      end
   endtask

   task automatic test_backpressure();
      logic [OUT_W-1:0] exp_a;
      logic [OUT_W-1:0] exp_b;
      logic [OUT_W-1:0] g0;
      logic [OUT_W-1:0] g1;
      int n = 0;
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      got_q.delete();
      send_word(2'b01);
      model_cnt = model_cnt + 8'd1;
      exp_a = model_cnt;
      while (!(bus.m_valid === 1'b1 && bus.ackin === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      send_word(2'b01);
      model_cnt = model_cnt + 8'd1;
      exp_b = model_cnt;
      repeat (60) @(negedge clk);
      checks++;
      if (bus.ackin !== 1'b1 || bus.m_valid !== 1'b1 || bus.m_data !== exp_a) begin
         errors++;
         $display("FAIL bp_stall: ackin=%b m_valid=%b m_data=%0d required 1/1/%0d",
                  bus.ackin, bus.m_valid, bus.m_data, exp_a);
      end
      checks++;
      if (got_q.size() != 0 || (bus.t_out | bus.f_out) != '1) begin
         errors++;
         $display("FAIL bp_hold: transfers=%0d block outputs complete=%0d required 0/1",
                  got_q.size(), (bus.t_out | bus.f_out) == '1);
      end
      rdy_mode = 1;
      n = 0;
      while (got_q.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (got_q.size() < 2) begin
         errors++;
         $display("FAIL bp_release: transfers=%0d required 2", got_q.size());
      end else begin
         g0 = got_q.pop_front();
         g1 = got_q.pop_front();
         if (g0 !== exp_a || g1 !== exp_b) begin
            errors++;
            $display("FAIL bp_order: m_data=%0d,%0d required %0d,%0d", g0, g1, exp_a, exp_b);
         end
      end
   endtask

   task automatic test_illegal();
      logic [OUT_W-1:0] v;
      logic [OUT_W-1:0] g;
      int n = 0;
      wait_quiet();
      blk_en  = 1'b0;
      man_ack = 1'b1;
      v       = OUT_W'($urandom_range(0, 255)) | 8'h08;
      got_q.delete();
      man_t = v;
      man_f = ~v | 8'h08;
      repeat (10) @(negedge clk);
      checks++;
      if (bus.err[0] !== 1'b1) begin
         errors++;
         $display("FAIL illegal_flag: err[0]=%b required 1", bus.err[0]);
      end
      checks++;
      if (bus.m_valid !== 1'b0 || bus.ackin !== 1'b1 || got_q.size() != 0) begin
         errors++;
         $display("FAIL illegal_nocap: m_valid=%b ackin=%b transfers=%0d required 0/1/0",
                  bus.m_valid, bus.ackin, got_q.size());
      end
      man_f = ~v;
      while (got_q.size() == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (got_q.size() == 0) begin
         errors++;
         $display("FAIL illegal_recover: no capture within 50 cycles, required %0d", v);
      end else begin
         g = got_q.pop_front();
         if (g !== v) begin
            errors++;
            $display("FAIL illegal_recover: m_data=%0d required %0d", g, v);
         end
      end
      man_t = '0;
      man_f = '0;
      n = 0;
      while (bus.ackin !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.err[0] !== 1'b1 || bus.ackin !== 1'b1) begin
         errors++;
         $display("FAIL illegal_sticky: err[0]=%b ackin=%b required 1/1", bus.err[0], bus.ackin);
      end
   endtask

   task automatic test_reset_mid();
      man_ack = 1'b1;
      send_word(2'b10);
      #2;
      reset   = 1'b0;
      man_ack = 1'b0;
      #1;
      checks++;
      if (bus.t_in !== '0 || bus.f_in !== '0 || bus.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_null: t_in=%b f_in=%b s_ready=%b required 00/00/0",
                  bus.t_in, bus.f_in, bus.s_ready);
      end
      checks++;
      if (bus.err !== 2'b00 || bus.ackin !== 1'b1 || bus.m_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: err=%b ackin=%b m_valid=%b required 00/1/0",
                  bus.err, bus.ackin, bus.m_valid);
      end
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_wait_ack: s_ready=%b required 0 while ackout=0", bus.s_ready);
      end
      man_ack = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_sready_c1: s_ready=%b required 0", bus.s_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_sready_c2: s_ready=%b required 1", bus.s_ready);
      end
   endtask

`ifdef NCL_TIMEOUT_EN
   task automatic test_timeout();
      man_ack = 1'b1;
      send_word(2'b01);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (bus.err[1] !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: err[1]=%b required 0 after 20 cycles", bus.err[1]);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (bus.err[1] !== 1'b1 || bus.t_in !== 2'b01 || bus.f_in !== 2'b10) begin
         errors++;
         $display("FAIL timeout_flag: err[1]=%b t_in=%b f_in=%b required 1/01/10",
                  bus.err[1], bus.t_in, bus.f_in);
      end
   endtask
`endif

   initial begin
      test_reset();
      blk_en = 1'b1;
      test_count_up();
      test_clear_wrap();
      test_random();
      test_backpressure();
      test_illegal();
      test_reset_mid();
`ifdef NCL_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
